// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, opcode encodings and fetch state encoding.
package cpu_pkg;

    localparam int ADDR_W    = 8;
    localparam int INSTR_W   = 16;
    localparam int OPCODE_HI = 15;
    localparam int OPCODE_LO = 12;

    localparam logic [3:0] OP_ADD    = 4'h0;
    localparam logic [3:0] OP_SUB    = 4'h1;
    localparam logic [3:0] OP_LOAD   = 4'h2;
    localparam logic [3:0] OP_STORE  = 4'h3;
    localparam logic [3:0] OP_BRANCH = 4'h4;
    localparam logic [3:0] OP_JUMP   = 4'h5;
    localparam logic [3:0] OP_HALT   = 4'hF;

    typedef enum logic [0:0] {
        FS_RUN  = 1'b0,
        FS_HALT = 1'b1
    } fetch_state_e;

    // Instruction words are 2 bytes, so every fetch address is even.
    function automatic logic [ADDR_W-1:0] align_pc(input logic [ADDR_W-1:0] addr);
        return {addr[ADDR_W-1:1], 1'b0};
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: valid/ready holding register with flush.
module if_id_reg
    import cpu_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               load,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic [ADDR_W-1:0]  in_pc,
    input  logic               out_ready,
    output logic               out_valid,
    output logic [INSTR_W-1:0] out_instr,
    output logic [ADDR_W-1:0]  out_pc
);

    logic               valid_r;
    logic [INSTR_W-1:0] instr_r;
    logic [ADDR_W-1:0]  pc_r;

    // Capture, flush, drain-on-accept or hold the fetched word.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_r <= 1'b0;
            instr_r <= 16'h0000;
            pc_r    <= 8'h00;
        end else if (flush) begin
            valid_r <= 1'b0;
        end else if (load) begin
            valid_r <= 1'b1;
            instr_r <= in_instr;
            pc_r    <= in_pc;
        end else if (out_ready) begin
            valid_r <= 1'b0;
        end else begin
            valid_r <= valid_r;
        end
    end

    assign out_valid = valid_r;
    assign out_instr = instr_r;
    assign out_pc    = pc_r;

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: program counter, redirect handling and IF/ID register toward decode.
// Optional HALT detection is enabled by defining FETCH_HALT_DETECT_EN.
module instruction_fetch
    import cpu_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = 8'h00,
    parameter int                PC_STEP  = 2
`ifdef FETCH_HALT_DETECT_EN
    ,
    parameter logic [3:0]        HALT_OPCODE = OP_HALT
`endif
) (
    input  logic               clk,
    input  logic               rst,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_instr,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_addr,
    output logic               out_valid,
    output logic [INSTR_W-1:0] out_instr,
    output logic [ADDR_W-1:0]  out_pc,
    input  logic               out_ready,
    output logic               halted
);

    localparam logic [ADDR_W-1:0] PC_INC = ADDR_W'(PC_STEP);

    fetch_state_e      state_r;
    fetch_state_e      state_next_s;
    logic [ADDR_W-1:0] pc_r;
    logic [ADDR_W-1:0] pc_next_s;
    logic              load_en_s;
    logic              halt_hit_s;

    // New words enter only in RUN, never on a redirect, and only when the register is free.
    assign load_en_s = (state_r == FS_RUN) && !redirect_valid && (!out_valid || out_ready);

`ifdef FETCH_HALT_DETECT_EN
    assign halt_hit_s = load_en_s && (imem_instr[OPCODE_HI:OPCODE_LO] == HALT_OPCODE);
    assign halted     = (state_r == FS_HALT);
`else
    assign halt_hit_s = 1'b0;
    assign halted     = 1'b0;
`endif

    // Next PC and fetch state; a redirect always wins.
    always_comb begin
        state_next_s = state_r;
        pc_next_s    = pc_r;
        case (state_r)
            FS_RUN: begin
                if (redirect_valid) begin
                    pc_next_s = align_pc(redirect_addr);
                end else if (load_en_s) begin
                    pc_next_s = pc_r + PC_INC;
                    if (halt_hit_s) begin
                        state_next_s = FS_HALT;
                    end else begin
                        state_next_s = FS_RUN;
                    end
                end else begin
                    pc_next_s = pc_r;
                end
            end
            FS_HALT: begin
                if (redirect_valid) begin
                    pc_next_s    = align_pc(redirect_addr);
                    state_next_s = FS_RUN;
                end else begin
                    state_next_s = FS_HALT;
                end
            end
            default: begin
                state_next_s = FS_RUN;
                pc_next_s    = align_pc(RESET_PC);
            end
        endcase
    end

    // PC and state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_r    <= align_pc(RESET_PC);
            state_r <= FS_RUN;
        end else begin
            pc_r    <= pc_next_s;
            state_r <= state_next_s;
        end
    end

    assign imem_addr = pc_r;

    if_id_reg u_if_id_reg (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect_valid),
        .load      (load_en_s),
        .in_instr  (imem_instr),
        .in_pc     (pc_r),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_instr (out_instr),
        .out_pc    (out_pc)
    );

endmodule
